// File: rtl/task1_req_arbiter.sv
// task1_req_arbiter: round-robin arbiter sharing one task1 datapath among requesters
module task1_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DP_LAT = 1,
  parameter int CNT_W = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           dp_in,
  input  logic                 dp_o1,
  input  logic                 dp_o2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_o1,
  output logic                 rsp_o2,
  input  logic                 stats_clr,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic                 mismatch_seen
);
  localparam int WC_W = DP_LAT > 1 ? $clog2(DP_LAT) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, grant, id, j;
  logic [7:0] data;
  logic [WC_W-1:0] wait_cnt;
  logic acc, cap;
  always_comb begin
    grant = rr_ptr;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[j]) grant = j;
    end
    acc = state == IDLE && |req_valid;
    cap = state == WAIT && wait_cnt == WC_W'(DP_LAT - 1);
    req_ready = acc ? NUM_REQ'(1) << grant : '0;
    state_n = acc ? WAIT : cap ? RESP : (state == RESP && rsp_ready) ? IDLE : state;
    dp_in = state == IDLE ? 8'h00 : data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      data <= '0;
      id <= '0;
      wait_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_o1 <= 1'b0;
      rsp_o2 <= 1'b0;
      mismatch_cnt <= '0;
      mismatch_seen <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        data <= req_data[8*grant +: 8];
        id <= grant;
        rr_ptr <= ID_W'((int'(grant) + 1) % NUM_REQ);
        wait_cnt <= '0;
      end
      if (state == WAIT && !cap) wait_cnt <= wait_cnt + WC_W'(1);
      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_id <= id;
        rsp_o1 <= dp_o1;
        rsp_o2 <= dp_o2;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      // a clear coincident with a mismatch capture wins
      if (stats_clr) begin
        mismatch_cnt <= '0;
        mismatch_seen <= 1'b0;
      end else if (cap && dp_o1 != dp_o2) begin
        if (!(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
        mismatch_seen <= 1'b1;
      end
    end
  end
endmodule
